// File: rtl/ascon_input_packer_if.sv
// Handshake bundle for the Ascon input packer: narrow word stream in, padded rate block out.
// The packer uses the slave view; producer/consumer logic (or a bench) uses the master view.
interface ascon_input_packer_if #(
  parameter int IN_WIDTH    = 32,
  parameter int BLOCK_WIDTH = 128
);
  logic                               in_valid_i;
  logic                               in_ready_o;
  logic [IN_WIDTH-1:0]                in_data_i;
  logic [$clog2(IN_WIDTH/8):0]        in_bytes_i;
  logic                               in_last_i;
  logic                               in_ad_i;
  logic                               blk_valid_o;
  logic                               blk_ready_i;
  logic [BLOCK_WIDTH-1:0]             blk_data_o;
  logic [$clog2(BLOCK_WIDTH/8):0]     blk_bytes_o;
  logic                               blk_last_o;
  logic                               blk_ad_o;

  modport slave (
    input  in_valid_i, in_data_i, in_bytes_i, in_last_i, in_ad_i, blk_ready_i,
    output in_ready_o, blk_valid_o, blk_data_o, blk_bytes_o, blk_last_o, blk_ad_o
  );

  modport master (
    output in_valid_i, in_data_i, in_bytes_i, in_last_i, in_ad_i, blk_ready_i,
    input  in_ready_o, blk_valid_o, blk_data_o, blk_bytes_o, blk_last_o, blk_ad_o
  );
endinterface

// File: rtl/ascon_input_packer.sv
// Packs narrow AD/message words into rate blocks with Ascon 10* padding (extra pad block when aligned).
// Block valid one cycle after the completing word; input stalls (ready low) while a block is held for blk_ready_i.
module ascon_input_packer #(
  parameter int IN_WIDTH    = 32,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  ascon_input_packer_if.slave bus
);

  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int BLK_BYTES = BLOCK_WIDTH / 8;
  localparam int IBW       = $clog2(IN_BYTES) + 1;
  localparam int BBW       = $clog2(BLK_BYTES) + 1;

  typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_t;

  state_t                 r_state;
  logic [BLOCK_WIDTH-1:0] r_acc;
  logic [BBW-1:0]         r_fill;
  logic [BBW-1:0]         r_bytes;
  logic                   r_pad_pend;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_ad;

  logic [IBW-1:0]         w_n;
  logic [BBW-1:0]         w_new_fill;
  logic                   w_full;
  logic [IN_WIDTH-1:0]    w_mask_data;
  logic [BLOCK_WIDTH-1:0] w_acc;

  // Bytes above fill are always zero in r_acc, so placement is a plain OR of the shifted word.
  always_comb begin
    w_n = IBW'(IN_BYTES);
    if (bus.in_last_i && (bus.in_bytes_i < IBW'(IN_BYTES))) begin
      w_n = bus.in_bytes_i;
    end
    w_new_fill  = r_fill + BBW'(w_n);
    w_full      = (w_new_fill >= BBW'(BLK_BYTES));
    w_mask_data = '0;
    for (int j = 0; j < IN_BYTES; j++) begin
      if (IBW'(j) < w_n) begin
        w_mask_data[j*8 +: 8] = bus.in_data_i[j*8 +: 8];
      end
    end
    w_acc = r_acc | (BLOCK_WIDTH'(w_mask_data) << {r_fill, 3'b000});
    if (bus.in_last_i && !w_full) begin
      w_acc = w_acc | (BLOCK_WIDTH'(1) << {w_new_fill, 3'b000});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= FILL;
      r_acc      <= '0;
      r_fill     <= '0;
      r_bytes    <= '0;
      r_pad_pend <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_ad       <= 1'b0;
    end else if (clear_i) begin
      r_state    <= FILL;
      r_acc      <= '0;
      r_fill     <= '0;
      r_pad_pend <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (bus.in_valid_i) begin
            if (r_fill == '0) begin
              r_ad <= bus.in_ad_i;
            end
            r_acc  <= w_acc;
            r_fill <= w_new_fill;
            if (w_full) begin
              r_state    <= EMIT;
              r_valid    <= 1'b1;
              r_bytes    <= BBW'(BLK_BYTES);
              r_last     <= 1'b0;
              r_pad_pend <= bus.in_last_i;
            end else if (bus.in_last_i) begin
              r_state <= EMIT;
              r_valid <= 1'b1;
              r_bytes <= w_new_fill;
              r_last  <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.blk_ready_i) begin
            r_fill <= '0;
            if (r_pad_pend) begin
              // Standalone padding block: 0x01 at byte 0, no data bytes.
              r_state <= EMIT_PAD;
              r_acc   <= BLOCK_WIDTH'(1);
              r_bytes <= '0;
              r_last  <= 1'b1;
            end else begin
              r_state <= FILL;
              r_acc   <= '0;
              r_valid <= 1'b0;
            end
          end
        end
        EMIT_PAD: begin
          if (bus.blk_ready_i) begin
            r_state    <= FILL;
            r_acc      <= '0;
            r_pad_pend <= 1'b0;
            r_valid    <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == FILL);
  assign bus.blk_valid_o = r_valid;
  assign bus.blk_data_o  = r_acc;
  assign bus.blk_bytes_o = r_bytes;
  assign bus.blk_last_o  = r_last;
  assign bus.blk_ad_o    = r_ad;

endmodule

// File: doc/ascon_input_packer.md
# ascon_input_packer

Parametrised input packer and padder for the Ascon-AEAD128 datapath. It accepts associated-data or plaintext/ciphertext as a stream of narrow words over a valid/ready handshake and assembles them into rate-sized blocks. It applies Ascon 10* byte padding to the final partial block, or appends a standalone padding block when a segment ends block-aligned. It sits between the subsystem bus/FIFO front end and the permutation/absorb controller, and is the buffered successor of the purely combinational pad selector.

## Interface
- `IN_WIDTH`, 32: input word width in bits; multiple of 8; `BLOCK_WIDTH` is a multiple of `IN_WIDTH`.
- `BLOCK_WIDTH`, 128: rate/block width in bits, taken from `ascon_pack`.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `clear_i`  in  1  synchronous abort; discards the partial block and any pending output.
- `in_valid_i`  in  1  input word valid.
- `in_ready_o`  out  1  input word accepted when high together with `in_valid_i`.
- `in_data_i`  in  `IN_WIDTH`  input word, little-endian bytes (byte 0 = bits 7:0).
- `in_bytes_i`  in  `$clog2(IN_WIDTH/8)+1`  valid byte count, 0..`IN_WIDTH/8`; honoured only with `in_last_i`, otherwise treated as full.
- `in_last_i`  in  1  last word of the current segment.
- `in_ad_i`  in  1  segment type, 1 = associated data; held stable for a whole segment.
- `blk_valid_o`  out  1  output block valid.
- `blk_ready_i`  in  1  downstream accepts the block.
- `blk_data_o`  out  `BLOCK_WIDTH`  padded block.
- `blk_bytes_o`  out  `$clog2(BLOCK_WIDTH/8)+1`  number of data (non-pad) bytes in the block, 0..16.
- `blk_last_o`  out  1  final block of the segment.
- `blk_ad_o`  out  1  segment type latched from the first word of the block.

## Operation
- Accumulator `acc` (`BLOCK_WIDTH`) and byte counter `fill` (0..`BLOCK_WIDTH/8`).
- States: FILL, EMIT, EMIT_PAD.
- FILL, `in_ready_o`=1. On an accepted word with n bytes (n = `IN_WIDTH/8` unless last):
  - Byte j is written to `acc` byte `fill+j`, and `fill += n`.
  - `blk_ad_o` is latched from `in_ad_i` when `fill` is 0.
- FILL, non-last word, `fill` reaches `BLOCK_WIDTH/8`: go to EMIT with `last`=0 and `bytes`=16.
- FILL, last word, resulting `fill` < 16:
  - Write 0x01 to byte `fill` and force all higher bytes to 0.
  - Go to EMIT with `last`=1 and `bytes`=`fill`.
  - This covers `in_bytes_i`=0, which gives an empty segment, or a pad at a word-aligned position.
- FILL, last word, resulting `fill` = 16: go to EMIT with `last`=0 and set the `pad_pend` flag.
- EMIT, `blk_valid_o`=1, `in_ready_o`=0:
  - `blk_data_o`, `blk_bytes_o`, `blk_last_o` and `blk_ad_o` are held stable until `blk_ready_i`.
  - On handshake, clear `fill` and `acc`.
  - Then go to EMIT_PAD if `pad_pend` is set, else to FILL.
- EMIT_PAD:
  - Outputs `blk_data_o` = 128'h1, `blk_bytes_o`=0, `blk_last_o`=1, with the same `blk_ad_o`.
  - Clear `pad_pend` on handshake and go to FILL.
- `clear_i` has priority over every other event:
  - Next state is FILL, with `fill`, `acc` and `pad_pend` = 0 and `blk_valid_o` low.
  - An input word presented in the same cycle is dropped, even though ready is high.
- Non-last words are always full, so block alignment is preserved and `fill` never overflows. A partial word without `in_last_i` is a protocol error, and its bytes are treated as full.

## Timing
- Reset values:
  - State FILL, so `in_ready_o`=1.
  - `blk_valid_o`=0, `blk_data_o`=0, `blk_bytes_o`=0, `blk_last_o`=0, `blk_ad_o`=0.
  - `fill`=0, `pad_pend`=0.
- Latency: `blk_valid_o` rises the cycle after the word that completes or ends the block is accepted.
- There is no input/output overlap: a 128-bit block at `IN_WIDTH`=32 costs at least 4 input cycles plus 1 emit cycle.
- An aligned segment end costs 2 emit cycles, with the padding block directly after the data block.
- All outputs come straight from registers; `in_ready_o` is decoded from state only, with no combinational path from `blk_ready_i`.
- Reset asserted mid-block or mid-EMIT returns all outputs to reset values asynchronously, and the block is lost.

## Test plan
- AD bytes 0x00..0x0F as 4 full words, last on the 4th -> block 128'h0F0E0D0C_0B0A0908_07060504_03020100 with bytes=16, last=0, ad=1; next block 128'h1 with bytes=0, last=1.
- Message words 32'h03020100 (full) then 32'h00000004 with `in_bytes_i`=1, last -> block 128'h0000..0001_0403020100 (0x01 at byte 5), bytes=5, last=1, ad=0.
- Empty segment, first word with `in_bytes_i`=0 and last -> single block 128'h1, bytes=0, last=1. Word `in_bytes_i`=4 last after 2 full words -> 0x01 at byte 12.
- Hold `blk_ready_i` low 3 cycles during EMIT -> outputs stable and `in_ready_o`=0 throughout. The following word is accepted the cycle after the handshake and lands at byte 0.
- `clear_i` after 2 accepted words -> no block emitted, and the next segment starts at byte 0. `clear_i` during EMIT_PAD -> padding block dropped, `blk_valid_o` low next cycle.
- Drop `rst_ni` mid-EMIT -> `blk_valid_o`=0 immediately. After release, a fresh 5-byte segment yields the block from scenario 2 exactly.
